// File: rtl/cpu65xx_serial_alu.sv
// Byte-serial 65xx ALU: an 8-bit datapath steps through the operand one byte per cycle,
// LSB-first for add/shift-left and MSB-first for shift-right, with optional BCD adjust.
module cpu65xx_serial_alu #(
    parameter int unsigned WIDTH      = 16,
    parameter bit          DECIMAL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    output logic             done,
    input  logic [3:0]       operation,
    input  logic [2:0]       opExtension,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             carryIn,
    input  logic             overflowIn,
    input  logic             decimalMode,
    output logic [WIDTH-1:0] result,
    output logic             carryOut,
    output logic             overflowOut,
    output logic             zero,
    output logic             negative
);

    localparam int unsigned BYTES    = WIDTH / 8;
    localparam logic [2:0]  LastStep = 3'(BYTES - 1);

    localparam logic [3:0] ALU_OP_ADC = 4'h0;
    localparam logic [3:0] ALU_OP_SBC = 4'h1;
    localparam logic [3:0] ALU_OP_CMP = 4'h2;
    localparam logic [3:0] ALU_OP_AND = 4'h3;
    localparam logic [3:0] ALU_OP_OR  = 4'h4;
    localparam logic [3:0] ALU_OP_EOR = 4'h5;
    localparam logic [3:0] ALU_OP_BIT = 4'h6;
    localparam logic [3:0] ALU_OP_INC = 4'h7;
    localparam logic [3:0] ALU_OP_DEC = 4'h8;
    localparam logic [3:0] ALU_OP_SGL = 4'h9;

    localparam logic [2:0] ALU_SOP_ASL = 3'd0;
    localparam logic [2:0] ALU_SOP_LSR = 3'd1;
    localparam logic [2:0] ALU_SOP_ROL = 3'd2;
    localparam logic [2:0] ALU_SOP_ROR = 3'd3;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q;
    logic [3:0]         op_q;
    logic [2:0]         sop_q;
    logic [WIDTH-1:0]   a_q, b_q, work_q, result_q;
    logic               cin_q, vin_q, dec_q, chain_q, zacc_q, done_q;
    logic [2:0]         step_q;
    logic               carry_q, ovf_q, zero_q, neg_q;

    logic               is_shift, msb_first, bcd_add, bcd_sub, chain_init;
    logic [2:0]         idx;
    logic [5:0]         sh;
    logic [7:0]         a_byte, b_byte, b_term, byte_out;
    logic [4:0]         lo_raw, hi_raw;
    logic               lo_c, hi_c, chain_d;
    logic [3:0]         lo_n, hi_n;
    logic [WIDTH-1:0]   work_d;
    logic               bp_msb, carry_fin, ovf_fin, neg_fin;

    always_comb begin
        chain_init = 1'b0;
        case (operation)
            ALU_OP_ADC, ALU_OP_SBC: chain_init = carryIn;
            ALU_OP_CMP, ALU_OP_INC: chain_init = 1'b1;
            ALU_OP_SGL: chain_init = carryIn &&
                                     (opExtension == ALU_SOP_ROL || opExtension == ALU_SOP_ROR);
            default:    chain_init = 1'b0;
        endcase
    end

    always_comb begin
        is_shift  = (op_q == ALU_OP_SGL) && (sop_q <= ALU_SOP_ROR);
        msb_first = (op_q == ALU_OP_SGL) && (sop_q == ALU_SOP_LSR || sop_q == ALU_SOP_ROR);
        idx       = msb_first ? (LastStep - step_q) : step_q;
        sh        = {idx, 3'b000};
        a_byte    = 8'(a_q >> sh);
        b_byte    = 8'(b_q >> sh);

        case (op_q)
            ALU_OP_SBC, ALU_OP_CMP: b_term = ~b_byte;
            ALU_OP_INC:             b_term = 8'h00;
            ALU_OP_DEC:             b_term = 8'hFF;
            default:                b_term = b_byte;
        endcase

        bcd_add = DECIMAL_EN && dec_q && (op_q == ALU_OP_ADC);
        bcd_sub = DECIMAL_EN && dec_q && (op_q == ALU_OP_SBC);

        // Subtraction works on A + ~B, so its nibble borrow is the binary nibble carry.
        lo_raw = {1'b0, a_byte[3:0]} + {1'b0, b_term[3:0]} + {4'b0, chain_q};
        if (bcd_add) begin
            lo_c = lo_raw > 5'd9;
            lo_n = lo_c ? lo_raw[3:0] + 4'd6 : lo_raw[3:0];
        end else if (bcd_sub) begin
            lo_c = lo_raw[4];
            lo_n = lo_c ? lo_raw[3:0] : lo_raw[3:0] + 4'd10;
        end else begin
            lo_c = lo_raw[4];
            lo_n = lo_raw[3:0];
        end

        hi_raw = {1'b0, a_byte[7:4]} + {1'b0, b_term[7:4]} + {4'b0, lo_c};
        if (bcd_add) begin
            hi_c = hi_raw > 5'd9;
            hi_n = hi_c ? hi_raw[3:0] + 4'd6 : hi_raw[3:0];
        end else if (bcd_sub) begin
            hi_c = hi_raw[4];
            hi_n = hi_c ? hi_raw[3:0] : hi_raw[3:0] + 4'd10;
        end else begin
            hi_c = hi_raw[4];
            hi_n = hi_raw[3:0];
        end

        byte_out = 8'h00;
        chain_d  = chain_q;
        case (op_q)
            ALU_OP_ADC, ALU_OP_SBC, ALU_OP_CMP, ALU_OP_INC, ALU_OP_DEC: begin
                byte_out = {hi_n, lo_n};
                chain_d  = hi_c;
            end
            ALU_OP_AND, ALU_OP_BIT: byte_out = a_byte & b_byte;
            ALU_OP_OR:              byte_out = a_byte | b_byte;
            ALU_OP_EOR:             byte_out = a_byte ^ b_byte;
            ALU_OP_SGL: begin
                if (is_shift && msb_first) begin
                    byte_out = {chain_q, a_byte[7:1]};
                    chain_d  = a_byte[0];
                end else if (is_shift) begin
                    byte_out = {a_byte[6:0], chain_q};
                    chain_d  = a_byte[7];
                end
            end
            default: byte_out = 8'h00;
        endcase

        work_d = (work_q & ~(WIDTH'(8'hFF) << sh)) | (WIDTH'(byte_out) << sh);

        carry_fin = (op_q == ALU_OP_ADC || op_q == ALU_OP_SBC || op_q == ALU_OP_CMP || is_shift)
                    ? chain_q : cin_q;
        bp_msb    = (op_q == ALU_OP_SBC) ? ~b_q[WIDTH-1] : b_q[WIDTH-1];
        case (op_q)
            ALU_OP_ADC, ALU_OP_SBC: ovf_fin = a_q[WIDTH-1] ^ bp_msb ^ work_q[WIDTH-1] ^ chain_q;
            ALU_OP_BIT:             ovf_fin = b_q[WIDTH-2];
            default:                ovf_fin = vin_q;
        endcase
        neg_fin = (op_q == ALU_OP_BIT) ? b_q[WIDTH-1] : work_q[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= '0;
            sop_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            vin_q    <= 1'b0;
            dec_q    <= 1'b0;
            chain_q  <= 1'b0;
            step_q   <= '0;
            work_q   <= '0;
            zacc_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q    <= operation;
                        sop_q   <= opExtension;
                        a_q     <= operandA;
                        b_q     <= operandB;
                        cin_q   <= carryIn;
                        vin_q   <= overflowIn;
                        dec_q   <= decimalMode;
                        chain_q <= chain_init;
                        step_q  <= '0;
                        work_q  <= '0;
                        zacc_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    work_q  <= work_d;
                    chain_q <= chain_d;
                    zacc_q  <= zacc_q & (byte_out == 8'h00);
                    step_q  <= step_q + 3'd1;
                    if (step_q == LastStep) state_q <= StDone;
                end
                StDone: begin
                    // Final flags need the last chain carry and the finished MSB byte.
                    result_q <= work_q;
                    carry_q  <= carry_fin;
                    ovf_q    <= ovf_fin;
                    zero_q   <= zacc_q;
                    neg_q    <= neg_fin;
                    done_q   <= 1'b1;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready       = (state_q == StIdle);
    assign done        = done_q;
    assign result      = result_q;
    assign carryOut    = carry_q;
    assign overflowOut = ovf_q;
    assign zero        = zero_q;
    assign negative    = neg_q;

endmodule
